// File: rtl/mul_div_unit_if.sv
// Handshake/bus bundle between the EX stage and the multiply/divide unit.
// The master drives the op and operands; the slave returns busy, HI/LO and the MF result.
interface mul_div_unit_if;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUOut;

    modport master (
        output start, MDUOp, RD1, RD2,
        input  busy, HI, LO, MDUOut
    );

    modport slave (
        input  start, MDUOp, RD1, RD2,
        output busy, HI, LO, MDUOut
    );
endinterface

// File: rtl/mul_div_unit.sv
// Fixed-latency multiply/divide unit owning the HI/LO pair.
// Operands are latched at launch; the result is committed on the final busy edge.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [31:0]      a_q, b_q;
    logic [31:0]      hi_q, lo_q;

    logic             is_arith, launch, done, busy;
    logic [31:0]      mdu_out;

    assign is_arith = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU) ||
                      (bus.MDUOp == OP_DIV)  || (bus.MDUOp == OP_DIVU);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start && is_arith) state_nxt = S_BUSY;
            S_BUSY: if (cnt == CNT_ONE)        state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = (state == S_BUSY);
        launch  = (state == S_IDLE) && bus.start && is_arith;
        done    = (state == S_BUSY) && (cnt == CNT_ONE);
        mdu_out = 32'h0;
        case (bus.MDUOp)
            OP_MFHI: mdu_out = hi_q;
            OP_MFLO: mdu_out = lo_q;
            default: mdu_out = 32'h0;
        endcase
    end

    // Arithmetic on the latched operands
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'h0, a_q} * {32'h0, b_q};
        a_neg  = (op_q == OP_DIV) && a_q[31];
        b_neg  = (op_q == OP_DIV) && b_q[31];
        // Magnitude form also covers 0x80000000 / -1: the quotient wraps back to 0x80000000
        a_mag  = a_neg ? (32'h0 - a_q) : a_q;
        b_mag  = b_neg ? (32'h0 - b_q) : b_q;
        b_safe = (b_mag == 32'h0) ? 32'h1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
        rem    = a_neg ? (32'h0 - r_mag) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= 4'h0;
            a_q  <= 32'h0;
            b_q  <= 32'h0;
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else begin
            if (launch) begin
                op_q <= bus.MDUOp;
                a_q  <= bus.RD1;
                b_q  <= bus.RD2;
                cnt  <= ((bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU)) ?
                        CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (busy) begin
                cnt <= cnt - CNT_ONE;
            end

            if (done) begin
                case (op_q)
                    OP_MULT:  {hi_q, lo_q} <= prod_s;
                    OP_MULTU: {hi_q, lo_q} <= prod_u;
                    OP_DIV, OP_DIVU: begin
                        if (b_q != 32'h0) begin
                            hi_q <= rem;
                            lo_q <= quot;
                        end
                    end
                    default: ;
                endcase
            end else if (!busy) begin
                // Moves to HI/LO only land while idle; the hazard unit stalls them otherwise
                if (bus.MDUOp == OP_MTHI) hi_q <= bus.RD1;
                if (bus.MDUOp == OP_MTLO) lo_q <= bus.RD1;
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.MDUOut = mdu_out;
endmodule
